ghost_mode_sched: RTL and testbench
===================================

// Module: ghost_mode_sched
// PURPOSE
//  Central scheduler for the ghost movement blocks. Divides sysclk into game ticks, drives the
//  per-tick update window that walks each ghost FSM, and sequences the shared mode bus
//  (Chase/Scatter/Frightened/Eaten, one-hot). Also generates the rotate (reverse) request.
//  One instance feeds mode/rotate/update to all ghost instances.
// PARAMETERS
//  TICK_DIV      833333  sysclk cycles per game tick (60 Hz at 50 MHz); must be > UPDATE_LEN+1
//  UPDATE_LEN    8       cycles update is held high per tick; ghost FSM needs >= 7
//  SCATTER_TICKS 420     ticks per scatter phase
//  CHASE_TICKS   1200    ticks per chase phase
//  FRIGHT_TICKS  360     ticks of frightened mode per power pellet
//  NUM_ROUNDS    4       scatter+chase rounds; after the last, chase is permanent
// PORTS
//  sysclk        in   1   system clock, all logic on posedge
//  resetn        in   1   asynchronous, active-low reset
//  enable        in   1   game running; gates the tick divider
//  power_pellet  in   1   1-cycle pulse: pacman ate power pellet
//  ghost_eaten   in   1   1-cycle pulse: pacman caught frightened ghost
//  ghost_home    in   1   1-cycle pulse: eaten ghost reached house target
//  mode          out  4   one-hot: 1000 Chase, 0100 Scatter, 0010 Frightened, 0001 Eaten
//  rotate        out  1   reverse-direction request to ghosts
//  update        out  1   ghost FSM advance window
//  tick          out  1   1-cycle game tick strobe
//  round         out  3   current scatter/chase round index, saturates at NUM_ROUNDS
// BEHAVIOUR
//  Reset: mode=0100, rotate=0, update=0, tick=0, round=0; all counters 0; internal state SCATTER.
//  Divider: 20-bit count 0..TICK_DIV-1 while enable=1; tick=1 for the cycle count==TICK_DIV-1.
//   enable=0 freezes count, no ticks; an update window in progress still completes.
//  Update: goes high the cycle after tick, stays high exactly UPDATE_LEN cycles, then low
//   (low >= 1 cycle guaranteed by TICK_DIV constraint).
//  Internal FSM (state changes on event cycle; timers count ticks, 16-bit, load N-1, expire at 0 on tick):
//   SCATTER: SCATTER_TICKS expiry -> CHASE. CHASE: CHASE_TICKS expiry -> SCATTER, round+=1;
//    once round==NUM_ROUNDS CHASE never expires.
//   SCATTER/CHASE + power_pellet -> FRIGHT; base mode and base timer saved/paused; fright timer
//    loaded with FRIGHT_TICKS.
//   FRIGHT + power_pellet -> reload fright timer, no state change, no rotate.
//   FRIGHT expiry -> saved base mode, base timer resumes where paused.
//   FRIGHT + ghost_eaten -> EATEN; fright timer cleared. ghost_eaten outside FRIGHT ignored.
//   EATEN + ghost_home -> saved base mode. power_pellet in EATEN ignored. Base timer paused in EATEN.
//   ghost_home outside EATEN ignored.
//  Simultaneous: ghost_eaten + fright expiry -> EATEN. power_pellet + base expiry -> base mode
//   advances (saved as the new base), FRIGHT entered, single rotate.
//   ghost_eaten + power_pellet in FRIGHT -> EATEN.
//  Output hold: mode register copies internal state only on cycles with update=0; during an update
//   window mode is frozen so a ghost sees one mode per walk. Pending change applies the first
//   cycle update=0.
//  Rotate: set in the same cycle mode output changes for SCATTER<->CHASE and SCATTER/CHASE->FRIGHT;
//   not for transitions to/from EATEN or FRIGHT->base. Held until the falling edge of the next
//   complete update window (cleared the cycle update drops), then 0.
//  Reset asserted mid-window: update, rotate drop immediately; all state returns to reset values.
// TESTING  (TICK_DIV=16, UPDATE_LEN=8, SCATTER=3, CHASE=5, FRIGHT=4, ROUNDS=2)
//  Reset release, enable=1 -> tick every 16 cycles; update high 8 cycles starting 1 after tick; mode=0100.
//  Free run -> mode 0100 for 3 ticks, 1000 for 5, 0100, 1000, then 1000 permanently, round=2;
//   rotate pulses high through one update window at each change.
//  power_pellet at tick 1 of scatter -> mode 0010 + rotate; 4 ticks later back to 0100,
//   scatter ends 2 ticks after return.
//  power_pellet during update high -> mode stays 1000 until update drops, then 0010.
//  In FRIGHT: ghost_eaten on fright-expiry cycle -> 0001, no rotate; ghost_home -> base mode, no rotate.
//  resetn low mid-window with mode=0010 -> update=0, rotate=0, mode=0100 asynchronously.

Source files
------------

// File: rtl/ghost_mode_sched.sv
// ghost_mode_sched
// Central scheduler shared by all ghost instances: divides sysclk into game ticks,
// opens a fixed-length update window after every tick, sequences the one-hot mode
// bus (Chase/Scatter/Frightened/Eaten) and raises the reverse-direction request.
module ghost_mode_sched #(
  parameter int unsigned TICK_DIV      = 833333,
  parameter int unsigned UPDATE_LEN    = 8,
  parameter int unsigned SCATTER_TICKS = 420,
  parameter int unsigned CHASE_TICKS   = 1200,
  parameter int unsigned FRIGHT_TICKS  = 360,
  parameter int unsigned NUM_ROUNDS    = 4
) (
  input  logic       sysclk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       power_pellet,
  input  logic       ghost_eaten,
  input  logic       ghost_home,
  output logic [3:0] mode,
  output logic       rotate,
  output logic       update,
  output logic       tick,
  output logic [2:0] round
);

  // Encoding chosen so that mode bit gi is simply (state == gi).
  typedef enum logic [1:0] {
    ST_EATEN   = 2'd0,
    ST_FRIGHT  = 2'd1,
    ST_SCATTER = 2'd2,
    ST_CHASE   = 2'd3
  } state_t;

  localparam logic [19:0] DIV_LAST     = 20'(TICK_DIV - 1);
  localparam logic [15:0] UPD_LAST     = 16'(UPDATE_LEN - 1);
  localparam logic [15:0] SCATTER_LAST = 16'(SCATTER_TICKS - 1);
  localparam logic [15:0] CHASE_LAST   = 16'(CHASE_TICKS - 1);
  localparam logic [15:0] FRIGHT_LAST  = 16'(FRIGHT_TICKS - 1);
  localparam logic [2:0]  ROUND_MAX    = 3'(NUM_ROUNDS);

  localparam logic [3:0] MODE_CHASE   = 4'b1000;
  localparam logic [3:0] MODE_SCATTER = 4'b0100;
  localparam logic [3:0] MODE_EATEN   = 4'b0001;

  // Tick divider
  logic [19:0] div_cnt_reg;
  logic        tick_pulse;

  // Update window
  logic [15:0] upd_cnt_reg;
  logic        update_reg;
  logic        update_fall;
  logic        mode_hold;

  // Mode sequencing
  state_t      state_reg, state_next;
  state_t      base_reg, base_next;
  state_t      adv_state;
  logic [15:0] base_cnt_reg, base_cnt_next;
  logic [15:0] fright_cnt_reg, fright_cnt_next;
  logic [2:0]  round_reg, round_next;

  // Output stage
  logic [3:0]  mode_reg, mode_next;
  logic        rotate_reg;
  logic        rotate_set;
  logic        base_mode_now;

  assign tick_pulse = enable && (div_cnt_reg == DIV_LAST);

  // Free-running tick divider, frozen while the game is paused.
  always_ff @(posedge sysclk or negedge resetn) begin
    if (!resetn) begin
      div_cnt_reg <= '0;
    end else if (enable) begin
      if (div_cnt_reg == DIV_LAST) begin
        div_cnt_reg <= '0;
      end else begin
        div_cnt_reg <= div_cnt_reg + 20'd1;
      end
    end
  end

  // Update window: opens the cycle after a tick and runs to completion even if paused.
  always_ff @(posedge sysclk or negedge resetn) begin
    if (!resetn) begin
      update_reg  <= 1'b0;
      upd_cnt_reg <= '0;
    end else if (tick_pulse) begin
      update_reg  <= 1'b1;
      upd_cnt_reg <= UPD_LAST;
    end else if (update_reg) begin
      if (upd_cnt_reg == '0) begin
        update_reg <= 1'b0;
      end else begin
        upd_cnt_reg <= upd_cnt_reg - 16'd1;
      end
    end
  end

  // The last high cycle of the window is the only one on which mode may be reloaded
  // while update is still 1, so the new mode appears together with update dropping.
  assign update_fall = update_reg && (upd_cnt_reg == '0);
  assign mode_hold   = update_reg && (upd_cnt_reg != '0);

  // Mode sequencer registers.
  always_ff @(posedge sysclk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= ST_SCATTER;
      base_reg       <= ST_SCATTER;
      base_cnt_reg   <= '0;
      fright_cnt_reg <= '0;
      round_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      base_reg       <= base_next;
      base_cnt_reg   <= base_cnt_next;
      fright_cnt_reg <= fright_cnt_next;
      round_reg      <= round_next;
    end
  end

  // Next-state logic: base schedule timing, frightened/eaten excursions and their priorities.
  always_comb begin
    state_next      = state_reg;
    base_next       = base_reg;
    base_cnt_next   = base_cnt_reg;
    fright_cnt_next = fright_cnt_reg;
    round_next      = round_reg;
    adv_state       = state_reg;

    case (state_reg)
      ST_SCATTER, ST_CHASE: begin
        // Advance the base schedule first; a pellet on the same cycle then
        // saves the advanced phase as the one to return to.
        if (tick_pulse) begin
          if (state_reg == ST_SCATTER) begin
            if (base_cnt_reg == SCATTER_LAST) begin
              adv_state     = ST_CHASE;
              base_cnt_next = '0;
            end else begin
              base_cnt_next = base_cnt_reg + 16'd1;
            end
          end else if (round_reg != ROUND_MAX) begin
            if (base_cnt_reg == CHASE_LAST) begin
              base_cnt_next = '0;
              round_next    = round_reg + 3'd1;
              // Completing the final round leaves the ghosts chasing for good.
              if ((round_reg + 3'd1) != ROUND_MAX) begin
                adv_state = ST_SCATTER;
              end
            end else begin
              base_cnt_next = base_cnt_reg + 16'd1;
            end
          end
        end
        base_next = adv_state;
        if (power_pellet) begin
          state_next      = ST_FRIGHT;
          fright_cnt_next = '0;
        end else begin
          state_next = adv_state;
        end
      end

      ST_FRIGHT: begin
        if (ghost_eaten) begin
          state_next      = ST_EATEN;
          fright_cnt_next = '0;
        end else if (power_pellet) begin
          fright_cnt_next = '0;
        end else if (tick_pulse) begin
          if (fright_cnt_reg == FRIGHT_LAST) begin
            state_next      = base_reg;
            fright_cnt_next = '0;
          end else begin
            fright_cnt_next = fright_cnt_reg + 16'd1;
          end
        end
      end

      default: begin
        if (ghost_home) begin
          state_next = base_reg;
        end
      end
    endcase
  end

  // One-hot mode image of the next internal state.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_mode_bit
      assign mode_next[gi] = (state_next == state_t'(2'(gi)));
    end
  endgenerate

  // Reversal is requested for scatter<->chase swaps and for entering frightened from a
  // base mode; eaten entries/exits and frightened->base returns are silent.
  assign base_mode_now = (mode_reg == MODE_CHASE) || (mode_reg == MODE_SCATTER);
  assign rotate_set    = !mode_hold && base_mode_now &&
                         (mode_next != mode_reg) && (mode_next != MODE_EATEN);

  // Mode is frozen across an update window; rotate lives until the next window ends.
  always_ff @(posedge sysclk or negedge resetn) begin
    if (!resetn) begin
      mode_reg   <= MODE_SCATTER;
      rotate_reg <= 1'b0;
    end else begin
      if (!mode_hold) begin
        mode_reg <= mode_next;
      end
      if (rotate_set) begin
        rotate_reg <= 1'b1;
      end else if (update_fall) begin
        rotate_reg <= 1'b0;
      end
    end
  end

  assign mode   = mode_reg;
  assign rotate = rotate_reg;
  assign update = update_reg;
  assign tick   = tick_pulse;
  assign round  = round_reg;

endmodule

// File: tb/tb_ghost_mode_sched.sv
// tb_ghost_mode_sched
// Timeline-based checks of ghost_mode_sched with a small parameter set. Expected
// output records are queued with the cycle they apply to and popped when the bench
// reaches that cycle. Sample point n = negedge following the n-th rising edge after enable.
module tb_ghost_mode_sched;

  localparam int TICK_DIV      = 16;
  localparam int UPDATE_LEN    = 8;
  localparam int SCATTER_TICKS = 3;
  localparam int CHASE_TICKS   = 5;
  localparam int FRIGHT_TICKS  = 4;
  localparam int NUM_ROUNDS    = 2;

  logic       sysclk = 1'b0;
  logic       resetn;
  logic       enable;
  logic       power_pellet;
  logic       ghost_eaten;
  logic       ghost_home;
  logic [3:0] mode;
  logic       rotate;
  logic       update;
  logic       tick;
  logic [2:0] round;

  ghost_mode_sched #(
    .TICK_DIV     (TICK_DIV),
    .UPDATE_LEN   (UPDATE_LEN),
    .SCATTER_TICKS(SCATTER_TICKS),
    .CHASE_TICKS  (CHASE_TICKS),
    .FRIGHT_TICKS (FRIGHT_TICKS),
    .NUM_ROUNDS   (NUM_ROUNDS)
  ) dut (
    .sysclk      (sysclk),
    .resetn      (resetn),
    .enable      (enable),
    .power_pellet(power_pellet),
    .ghost_eaten (ghost_eaten),
    .ghost_home  (ghost_home),
    .mode        (mode),
    .rotate      (rotate),
    .update      (update),
    .tick        (tick),
    .round       (round)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    int         cyc;
    logic [3:0] mode;
    logic       rotate;
    logic       update;
    logic       tick;
    logic [2:0] round;
  } vec_t;

  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] mode;
    logic       rotate;
    logic       update;
    logic       tick;
    logic [2:0] round;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[20];
  int   vectors = 0;
  int   miscompares = 0;
  int   n = 0;

  task automatic step();
    @(posedge sysclk);
    @(negedge sysclk);
    n++;
  endtask

  task automatic run_to(input int k);
    while (n < k) step();
  endtask

  task automatic expect_at(input int cyc, input string name, input logic [3:0] m,
                           input logic r, input logic u, input logic t, input logic [2:0] rd);
    exp_t e;
    e.cyc = cyc; e.name = name; e.mode = m; e.rotate = r;
    e.update = u; e.tick = t; e.round = rd;
    sb_q.push_back(e);
  endtask

  task automatic check_head();
    exp_t e;
    e = sb_q.pop_front();
    vectors++;
    if (n != e.cyc || mode !== e.mode || rotate !== e.rotate || update !== e.update ||
        tick !== e.tick || round !== e.round) begin
      miscompares++;
      $display("FAIL %s @%0d (due %0d): got mode=%b rot=%b upd=%b tick=%b round=%0d, want mode=%b rot=%b upd=%b tick=%b round=%0d",
               e.name, n, e.cyc, mode, rotate, update, tick, round,
               e.mode, e.rotate, e.update, e.tick, e.round);
    end else begin
      $display("ok   %s @%0d mode=%b rot=%b upd=%b tick=%b round=%0d",
               e.name, n, mode, rotate, update, tick, round);
    end
  endtask

  task automatic check_now(input string name, input logic [3:0] m, input logic r,
                           input logic u, input logic t, input logic [2:0] rd);
    expect_at(n, name, m, r, u, t, rd);
    check_head();
  endtask

  // Check every queued expectation due at or before cycle k, then stop at cycle k.
  task automatic drain_until(input int k);
    while (sb_q.size() > 0 && sb_q[0].cyc <= k) begin
      run_to(sb_q[0].cyc);
      check_head();
    end
    run_to(k);
  endtask

  // Reset, check the reset image, then release and enable; next step lands on n=0.
  task automatic do_reset();
    resetn = 1'b0; enable = 1'b0;
    power_pellet = 1'b0; ghost_eaten = 1'b0; ghost_home = 1'b0;
    @(negedge sysclk);
    @(negedge sysclk);
    check_now("reset", 4'b0100, 1'b0, 1'b0, 1'b0, 3'd0);
    resetn = 1'b1;
    @(negedge sysclk);
    enable = 1'b1;
    n = -1;
  endtask

  task automatic pulse_pp();
    power_pellet = 1'b1; step(); power_pellet = 1'b0;
  endtask

  task automatic pulse_ge();
    ghost_eaten = 1'b1; step(); ghost_eaten = 1'b0;
  endtask

  task automatic pulse_gh();
    ghost_home = 1'b1; step(); ghost_home = 1'b0;
  endtask

  initial begin
    // Free-run schedule: tick at n=16t-2, update high n=16t-1..16t+6.
    tbl[0]  = '{0,    4'b0100, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[1]  = '{14,   4'b0100, 1'b0, 1'b0, 1'b1, 3'd0};
    tbl[2]  = '{15,   4'b0100, 1'b0, 1'b1, 1'b0, 3'd0};
    tbl[3]  = '{22,   4'b0100, 1'b0, 1'b1, 1'b0, 3'd0};
    tbl[4]  = '{23,   4'b0100, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[5]  = '{46,   4'b0100, 1'b0, 1'b0, 1'b1, 3'd0};
    tbl[6]  = '{47,   4'b1000, 1'b1, 1'b1, 1'b0, 3'd0};
    tbl[7]  = '{54,   4'b1000, 1'b1, 1'b1, 1'b0, 3'd0};
    tbl[8]  = '{55,   4'b1000, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[9]  = '{126,  4'b1000, 1'b0, 1'b0, 1'b1, 3'd0};
    tbl[10] = '{127,  4'b0100, 1'b1, 1'b1, 1'b0, 3'd1};
    tbl[11] = '{135,  4'b0100, 1'b0, 1'b0, 1'b0, 3'd1};
    tbl[12] = '{174,  4'b0100, 1'b0, 1'b0, 1'b1, 3'd1};
    tbl[13] = '{175,  4'b1000, 1'b1, 1'b1, 1'b0, 3'd1};
    tbl[14] = '{183,  4'b1000, 1'b0, 1'b0, 1'b0, 3'd1};
    tbl[15] = '{254,  4'b1000, 1'b0, 1'b0, 1'b1, 3'd1};
    tbl[16] = '{255,  4'b1000, 1'b0, 1'b1, 1'b0, 3'd2};
    tbl[17] = '{263,  4'b1000, 1'b0, 1'b0, 1'b0, 3'd2};
    tbl[18] = '{400,  4'b1000, 1'b0, 1'b1, 1'b0, 3'd2};
    tbl[19] = '{1000, 4'b1000, 1'b0, 1'b0, 1'b0, 3'd2};

    // Free run
    do_reset();
    for (int i = 0; i < 20; i++) begin
      expect_at(tbl[i].cyc, $sformatf("freerun[%0d]", i), tbl[i].mode,
                tbl[i].rotate, tbl[i].update, tbl[i].tick, tbl[i].round);
    end
    drain_until(1000);

    // Pellet after the first scatter tick, stray eaten/home pulses ignored in scatter
    do_reset();
    expect_at(24, "pelA_pre", 4'b0100, 1'b0, 1'b0, 1'b0, 3'd0);
    drain_until(24);
    pulse_pp();
    expect_at(25, "pelA_fright", 4'b0010, 1'b1, 1'b0, 1'b0, 3'd0);
    expect_at(38, "pelA_rot_held", 4'b0010, 1'b1, 1'b1, 1'b0, 3'd0);
    expect_at(39, "pelA_rot_clr", 4'b0010, 1'b0, 1'b0, 1'b0, 3'd0);
    expect_at(78, "pelA_last_fr", 4'b0010, 1'b0, 1'b0, 1'b1, 3'd0);
    expect_at(79, "pelA_back", 4'b0100, 1'b0, 1'b1, 1'b0, 3'd0);
    drain_until(88);
    pulse_ge();
    pulse_gh();
    expect_at(92, "pelA_ignored", 4'b0100, 1'b0, 1'b0, 1'b0, 3'd0);
    expect_at(110, "pelA_sc_end", 4'b0100, 1'b0, 1'b0, 1'b1, 3'd0);
    expect_at(111, "pelA_chase", 4'b1000, 1'b1, 1'b1, 1'b0, 3'd0);
    drain_until(111);

    // Pellet during an update window, then eaten on the expiry tick, then home
    do_reset();
    expect_at(47, "pelB_chase", 4'b1000, 1'b1, 1'b1, 1'b0, 3'd0);
    expect_at(64, "pelB_pre", 4'b1000, 1'b0, 1'b1, 1'b0, 3'd0);
    drain_until(64);
    pulse_pp();
    expect_at(65, "pelB_frozen", 4'b1000, 1'b0, 1'b1, 1'b0, 3'd0);
    expect_at(70, "pelB_frozen_end", 4'b1000, 1'b0, 1'b1, 1'b0, 3'd0);
    expect_at(71, "pelB_fright", 4'b0010, 1'b1, 1'b0, 1'b0, 3'd0);
    expect_at(86, "pelB_rot_held", 4'b0010, 1'b1, 1'b1, 1'b0, 3'd0);
    expect_at(87, "pelB_rot_clr", 4'b0010, 1'b0, 1'b0, 1'b0, 3'd0);
    expect_at(126, "eat_expiry_tick", 4'b0010, 1'b0, 1'b0, 1'b1, 3'd0);
    drain_until(126);
    pulse_ge();
    expect_at(127, "eat_mode", 4'b0001, 1'b0, 1'b1, 1'b0, 3'd0);
    expect_at(136, "eat_hold", 4'b0001, 1'b0, 1'b0, 1'b0, 3'd0);
    drain_until(136);
    pulse_pp();
    expect_at(138, "eat_pellet_ign", 4'b0001, 1'b0, 1'b0, 1'b0, 3'd0);
    drain_until(140);
    pulse_gh();
    expect_at(141, "home_base", 4'b1000, 1'b0, 1'b0, 1'b0, 3'd0);
    expect_at(190, "home_chase_end", 4'b1000, 1'b0, 1'b0, 1'b1, 3'd0);
    expect_at(191, "home_scatter", 4'b0100, 1'b1, 1'b1, 1'b0, 3'd1);
    drain_until(191);

    // Pellet on the scatter-expiry tick: base advances to chase, one rotate
    do_reset();
    expect_at(46, "simul_pre", 4'b0100, 1'b0, 1'b0, 1'b1, 3'd0);
    drain_until(46);
    pulse_pp();
    expect_at(47, "simul_fright", 4'b0010, 1'b1, 1'b1, 1'b0, 3'd0);
    expect_at(55, "simul_rot_clr", 4'b0010, 1'b0, 1'b0, 1'b0, 3'd0);
    expect_at(110, "simul_last_fr", 4'b0010, 1'b0, 1'b0, 1'b1, 3'd0);
    expect_at(111, "simul_to_chase", 4'b1000, 1'b0, 1'b1, 1'b0, 3'd0);
    expect_at(191, "simul_chase_end", 4'b0100, 1'b1, 1'b1, 1'b0, 3'd1);
    drain_until(191);

    // Asynchronous reset in the middle of a frightened update window
    do_reset();
    drain_until(24);
    pulse_pp();
    expect_at(33, "arst_pre", 4'b0010, 1'b1, 1'b1, 1'b0, 3'd0);
    drain_until(33);
    resetn = 1'b0;
    #1;
    check_now("arst_async", 4'b0100, 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge sysclk);
    resetn = 1'b1;

    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: got %0d pending, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
